// File: rtl/booth_ctrl_param.sv
// Sequencer for a radix-2 Booth shift-add multiplier: one iteration counter drives WIDTH eval/shift rounds.
// Define BOOTH_MERGE_EN to fold each eval/shift pair into a single OP cycle (shift with add/sub).
module booth_ctrl_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          ClearA_LoadB,
  input  logic          Run,
  input  logic          M,
  input  logic          MP,
  output logic          load,
  output logic          clr_a,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
`ifdef BOOTH_MERGE_EN
  localparam logic [2:0] S_OP    = 3'd5;
`else
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;

  // Booth recoding of the (Q0, Q-1) pair: 10 subtracts, 01 adds, equal bits do nothing.
  logic do_add_c, do_sub_c;
  assign do_add_c = ~M &  MP;
  assign do_sub_c =  M & ~MP;

  // State and iteration counter; reset lands in IDLE without needing a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // Next state and decoded strobes; add/sub follow M/MP in the same cycle.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    load    = 1'b0;
    clr_a   = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        load = ClearA_LoadB;
        if (Run) begin
          state_d = S_CLR;
          iter_d  = '0;
        end
      end
      S_CLR: begin
        clr_a  = 1'b1;
        busy   = 1'b1;
        iter_d = '0;
`ifdef BOOTH_MERGE_EN
        state_d = S_OP;
`else
        state_d = S_EVAL;
`endif
      end
`ifdef BOOTH_MERGE_EN
      S_OP: begin
        busy  = 1'b1;
        shift = 1'b1;
        add   = do_add_c;
        sub   = do_sub_c;
        if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + CW'(1);
        end
      end
`else
      S_EVAL: begin
        busy    = 1'b1;
        add     = do_add_c;
        sub     = do_sub_c;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
        end else begin
          iter_d  = iter_q + CW'(1);
          state_d = S_EVAL;
        end
      end
`endif
      S_DONE: begin
        load = ClearA_LoadB;
        done = 1'b1;
        if (!Run) state_d = S_IDLE;
      end
      default: begin
        // Stray encodings look like IDLE and recover on the next edge.
        load    = ClearA_LoadB;
        state_d = S_IDLE;
      end
    endcase
  end

  assign iter = iter_q;

endmodule

// File: tb/tb_booth_ctrl_param.sv
// Randomised bench for booth_ctrl_param against a cycle-offset reference model.
// Build with BOOTH_MERGE_EN defined to exercise the merged OP variant at WIDTH=16.
module tb_booth_ctrl_param;

`ifdef BOOTH_MERGE_EN
  localparam int W      = 16;
  localparam bit MERGED = 1'b1;
`else
  localparam int W      = 8;
  localparam bit MERGED = 1'b0;
`endif
  localparam int CW    = $clog2(W);
  localparam int ITERS = MERGED ? W : 2 * W;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          ClearA_LoadB;
  logic          Run;
  logic          M;
  logic          MP;
  logic          load, clr_a, add, sub, shift, busy, done;
  logic [CW-1:0] iter;

  booth_ctrl_param #(.WIDTH(W)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .ClearA_LoadB (ClearA_LoadB),
    .Run          (Run),
    .M            (M),
    .MP           (MP),
    .load         (load),
    .clr_a        (clr_a),
    .add          (add),
    .sub          (sub),
    .shift        (shift),
    .busy         (busy),
    .done         (done),
    .iter         (iter)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since Run was taken, plus a done flag.
  bit m_active, m_done;
  int m_t, m_iter;
  int shift_seen, busy_seen, clr_seen;

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_t      = 0;
    m_iter   = 0;
  endtask

  task automatic model_edge(input logic run_s);
    if (m_active) begin
      m_t++;
      if (m_t == 2 + ITERS) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_iter   = W - 1;
      end else if (m_t >= 2) begin
        m_iter = MERGED ? (m_t - 2) : (m_t - 2) / 2;
      end
    end else if (m_done) begin
      if (!run_s) m_done = 1'b0;
    end else if (run_s) begin
      m_active = 1'b1;
      m_t      = 1;
      m_iter   = 0;
    end
  endtask

  task automatic check_all();
    int r;
    bit ev, sh;
    r  = m_t - 2;
    ev = m_active && (r >= 0) && (MERGED || (r % 2 == 0));
    sh = m_active && (r >= 0) && (MERGED || (r % 2 == 1));
    check("load",  32'(load),  32'(!m_active && ClearA_LoadB));
    check("clr_a", 32'(clr_a), 32'(m_active && m_t == 1));
    check("add",   32'(add),   32'(ev && !M && MP));
    check("sub",   32'(sub),   32'(ev && M && !MP));
    check("shift", 32'(shift), 32'(sh));
    check("busy",  32'(busy),  32'(m_active));
    check("done",  32'(done),  32'(m_done));
    check("iter",  32'(iter),  32'(m_iter));
    if (shift) shift_seen++;
    if (busy)  busy_seen++;
    if (clr_a) clr_seen++;
  endtask

  // One clock: model takes the edge, then new inputs are driven and outputs checked mid-cycle.
  task automatic step(input logic run_v, input logic clb_v);
    @(posedge Clk);
    model_edge(Run);
    #1;
    Run          = run_v;
    ClearA_LoadB = clb_v;
    M            = 1'($urandom_range(0, 1));
    MP           = 1'($urandom_range(0, 1));
    #1;
    check_all();
  endtask

  initial begin
    int first_done;
    Reset_n      = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b1;
    M            = 1'b1;
    MP           = 1'b0;
    model_reset();
    #2;
    check_all();
    ClearA_LoadB = 1'b0;
    #1;
    check_all();
    #9;
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom_range(0, 1)));

    // Single-cycle Run pulse: timing of clr_a, shifts, busy window and done.
    shift_seen = 0; busy_seen = 0; clr_seen = 0; first_done = -1;
    step(1'b1, 1'b0);
    for (int i = 1; i <= ITERS + 5; i++) begin
      step(1'b0, 1'b0);
      if (done && first_done < 0) first_done = i;
    end
    check("pulse_shifts", 32'(shift_seen), 32'(W));
    check("pulse_busy",   32'(busy_seen),  32'(1 + ITERS));
    check("pulse_clr",    32'(clr_seen),   32'd1);
    check("pulse_done_at", 32'(first_done), 32'(2 + ITERS));

    // Run held high: no restart from DONE, then drop and re-raise.
    clr_seen = 0;
    for (int i = 0; i < 41; i++) step(1'b1, 1'b0);
    check("hold_clr", 32'(clr_seen), 32'd1);
    check("hold_done", 32'(done), 32'd1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("restart_clr",  32'(clr_a), 32'd1);
    check("restart_iter", 32'(iter),  32'd0);
    for (int i = 0; i < ITERS + 3; i++) step(1'b0, 1'b0);

    // ClearA_LoadB high throughout a run.
    step(1'b1, 1'b1);
    for (int i = 0; i < ITERS + 4; i++) step(1'b0, 1'b1);

    // Asynchronous reset while iter == 3.
    step(1'b1, 1'b0);
    for (int i = 0; i < 2 * ITERS && !(m_active && m_iter == 3); i++) step(1'b1, 1'b0);
    check("reached_iter3", 32'(iter), 32'd3);
    #1;
    Reset_n = 1'b0;
    Run     = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    Reset_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("post_reset_idle", 32'(busy_seen), 32'd0);

    // Random Run/ClearA_LoadB traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
